branch_predictor: RTL and testbench

- Bimodal branch direction predictor for the fetch stage: a table of 2-bit saturating counters indexed by PC.
- The execute-stage comparator's resolved taken/not-taken outcome drives the update port.
- Prediction is registered and returned one cycle after lookup.
- An internal clear FSM initialises the table after reset, one entry per cycle.

---
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: 2-bit saturating counters indexed by PC.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the index.
module branch_predictor #(
   parameter int unsigned INDEX_BITS = 6,
   parameter logic [1:0]  INIT_STATE = 2'b01
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ready,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic        update_taken
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] IDX_ONE  = 1;
   localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [INDEX_BITS-1:0] r_clr_idx;
   logic [1:0]            r_table [ENTRIES];

   logic                  w_clearing;
   logic                  w_clr_last;
   logic                  w_up_en;
   logic [INDEX_BITS-1:0] w_lk_pc_idx;
   logic [INDEX_BITS-1:0] w_up_pc_idx;
   logic [INDEX_BITS-1:0] w_lk_idx;
   logic [INDEX_BITS-1:0] w_up_idx;
   logic [1:0]            w_lk_cnt;
   logic [1:0]            w_up_cnt;
   logic [1:0]            w_up_cnt_nxt;
   logic                  w_unused_pc_bits;

   assign w_lk_pc_idx = lookup_pc[INDEX_BITS+1:2];
   assign w_up_pc_idx = update_pc[INDEX_BITS+1:2];
   assign w_unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                               update_pc[31:INDEX_BITS+2], update_pc[1:0]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_CLEAR: w_state_nxt = w_clr_last ? S_READY : S_CLEAR;
         S_READY: w_state_nxt = S_READY;
      endcase
   end

   // Output decode
   always_comb begin
      w_clearing = (r_state == S_CLEAR);
      ready      = (r_state == S_READY);
   end

   assign w_clr_last = (r_clr_idx == IDX_LAST);
   assign w_up_en    = update_valid && !w_clearing;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_idx <= '0;
      end else if (w_clearing) begin
         r_clr_idx <= r_clr_idx + IDX_ONE;
      end
   end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [INDEX_BITS-1:0] r_ghr;

   // Both ports hash with the pre-shift history of this cycle
   assign w_lk_idx = w_lk_pc_idx ^ r_ghr;
   assign w_up_idx = w_up_pc_idx ^ r_ghr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr <= '0;
      end else if (w_up_en) begin
         r_ghr <= {r_ghr[INDEX_BITS-2:0], update_taken};
      end
   end
`else
   assign w_lk_idx = w_lk_pc_idx;
   assign w_up_idx = w_up_pc_idx;
`endif

   assign w_lk_cnt = r_table[w_lk_idx];
   assign w_up_cnt = r_table[w_up_idx];

   always_comb begin
      w_up_cnt_nxt = w_up_cnt;
      if (update_taken) begin
         if (w_up_cnt != 2'b11) w_up_cnt_nxt = w_up_cnt + 2'b01;
      end else begin
         if (w_up_cnt != 2'b00) w_up_cnt_nxt = w_up_cnt - 2'b01;
      end
   end

   // Table storage has no reset; the clear sequence owns initialisation
   always_ff @(posedge clk) begin
      if (w_clearing) begin
         r_table[r_clr_idx] <= INIT_STATE;
      end else if (w_up_en) begin
         r_table[w_up_idx] <= w_up_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_taken <= w_clearing ? 1'b0 : w_lk_cnt[1];
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: cycle model plus directed literals.
// Set BRANCH_PREDICTOR_GSHARE_EN for both DUT and bench to exercise gshare.
module tb_branch_predictor;

   logic        clk;
   logic        reset;
   logic        ready;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;

   int checks;
   int failures;
   bit chk_en;

   int m_cnt [64];
   int m_ghr;
   int m_clr;
   bit m_ready;
   bit m_pv;
   bit m_pt;

   branch_predictor dut (
      .clk          (clk),
      .reset        (reset),
      .ready        (ready),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .update_valid (update_valid),
      .update_pc    (update_pc),
      .update_taken (update_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) & 32'h3f);
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts clear cycles, then fills the table in one go
   initial begin
      int li;
      int ui;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_clr   = 0;
            m_ready = 0;
            m_pv    = 0;
            m_pt    = 0;
            m_ghr   = 0;
         end else if (!m_ready) begin
            m_pv = lookup_valid;
            if (lookup_valid) m_pt = 0;
            m_clr++;
            if (m_clr == 64) begin
               m_ready = 1;
               for (int i = 0; i < 64; i++) m_cnt[i] = 1;
            end
         end else begin
            li = idx_of(lookup_pc) ^ m_ghr;
            ui = idx_of(update_pc) ^ m_ghr;
            m_pv = lookup_valid;
            if (lookup_valid) m_pt = (m_cnt[li] >= 2);
            if (update_valid) begin
               if (update_taken) m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
               else m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
               m_ghr = ((m_ghr << 1) | int'(update_taken)) & 63;
`endif
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("cyc_ready", ready, m_ready);
            chk("cyc_pred_valid", pred_valid, m_pv);
            chk("cyc_pred_taken", pred_taken, m_pt);
         end
      end
   end

   // All stimulus tasks start and end on a falling edge
   task automatic upd(input logic [31:0] pc, input logic t);
      update_valid = 1'b1;
      update_pc    = pc;
      update_taken = t;
      @(negedge clk);
      update_valid = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc, input logic exp, input string nm);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      @(negedge clk);
      lookup_valid = 1'b0;
      chk({nm, "_valid"}, pred_valid, 1'b1);
      chk(nm, pred_taken, exp);
   endtask

   task automatic both(input logic [31:0] pc, input logic t, input logic exp,
                       input string nm);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      update_valid = 1'b1;
      update_pc    = pc;
      update_taken = t;
      @(negedge clk);
      lookup_valid = 1'b0;
      update_valid = 1'b0;
      chk(nm, pred_taken, exp);
   endtask

   // Entered on the falling edge where reset was released
   task automatic wait_clear(input bit stim);
      for (int k = 0; k < 64; k++) begin
         chk("clear_ready_low", ready, 1'b0);
         if (stim) begin
            lookup_valid = (k == 5);
            lookup_pc    = 32'h104;
            update_valid = (k >= 10 && k < 20) || (k == 63);
            update_pc    = 32'h104;
            update_taken = 1'b1;
         end
         @(negedge clk);
         if (stim && k == 5) begin
            chk("clear_lookup_valid", pred_valid, 1'b1);
            chk("clear_lookup_taken", pred_taken, 1'b0);
         end
      end
      lookup_valid = 1'b0;
      update_valid = 1'b0;
      chk("ready_at_64", ready, 1'b1);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      chk_en       = 0;
      reset        = 1'b1;
      lookup_valid = 1'b0;
      lookup_pc    = '0;
      update_valid = 1'b0;
      update_pc    = '0;
      update_taken = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_pred_valid", pred_valid, 1'b0);
      chk("rst_pred_taken", pred_taken, 1'b0);
      chk_en = 1;
      reset  = 1'b0;
      wait_clear(1'b1);
      look(32'h104, 1'b0, "after_clear_104");

`ifdef BRANCH_PREDICTOR_GSHARE_EN
      upd(32'h104, 1'b1);
      upd(32'h100, 1'b1);
      look(32'h100, 1'b0, "gshare_100_idx3");
      look(32'h108, 1'b1, "gshare_108_idx1");
`else
      upd(32'h104, 1'b1);
      upd(32'h104, 1'b1);
      look(32'h104, 1'b1, "trained_104");
      look(32'h108, 1'b0, "untrained_108");

      repeat (5) upd(32'h104, 1'b1);
      upd(32'h104, 1'b0);
      look(32'h104, 1'b1, "sat_hi_then_nt");
      upd(32'h104, 1'b0);
      look(32'h104, 1'b0, "sat_cnt_01");
      repeat (6) upd(32'h104, 1'b0);
      upd(32'h104, 1'b1);
      look(32'h104, 1'b0, "sat_lo_then_t");
      upd(32'h104, 1'b1);
      look(32'h104, 1'b1, "sat_lo_cnt_10");

      upd(32'h104, 1'b1);
      upd(32'h104, 1'b1);
      look(32'h204, 1'b1, "alias_204");
      both(32'h104, 1'b0, 1'b1, "same_cycle_old_11");
      look(32'h104, 1'b1, "after_conflict_10");
      both(32'h104, 1'b0, 1'b1, "same_cycle_old_10");
      look(32'h104, 1'b0, "after_conflict_01");
      @(negedge clk);
      chk("hold_pred_valid", pred_valid, 1'b0);
      chk("hold_pred_taken", pred_taken, 1'b0);
`endif

      upd(32'h104, 1'b1);
      upd(32'h104, 1'b1);
      lookup_valid = 1'b1;
      lookup_pc    = 32'h104;
      @(negedge clk);
      lookup_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_pred_valid", pred_valid, 1'b0);
      chk("async_rst_pred_taken", pred_taken, 1'b0);
      chk("async_rst_ready", ready, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_clear(1'b0);
      look(32'h104, 1'b0, "training_lost_104");
      look(32'h204, 1'b0, "training_lost_204");

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
